axis_axi_writer: RTL
====================

# axis_axi_writer

Byte-stream to AXI4 write-burst engine on the system `clock` domain. It sits between the USB bulk OUT stream and the `axi_ddr3_lite` write channels. It packs received bytes little-endian into 32-bit words and buffers up to one burst. It then issues INCR write bursts at an auto-incrementing address that never crosses a burst-size-aligned boundary, and reports completion and errors.

## Interface
- `WIDTH`, 32: AXI data width (fixed at 32).
- `ADDRS`, 27: AXI byte-address width.
- `REQID`, 4: AXI ID width.
- `BURST_LEN`, 16: maximum beats per burst (power of two, 2..16).
- `BASE_ADDR`, 0: byte address loaded at reset (word aligned).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `s_valid_i` / `s_ready_o` / `s_last_i` in/out/in 1: byte-stream handshake and end of packet.
- `s_data_i` in 8: stream byte.
- `awvalid_o` / `awready_i` out/in 1: AW handshake.
- `awaddr_o` out ADDRS: burst start byte address.
- `awid_o` out REQID: burst ID.
- `awlen_o` out 8: beats minus 1.
- `awburst_o` out 2: always 2'b01 (INCR).
- `wvalid_o` / `wready_i` / `wlast_o` out/in/out 1: W handshake.
- `wstrb_o` out 4: byte strobes.
- `wdata_o` out 32: write data.
- `bvalid_i` / `bready_o` in/out 1: B handshake.
- `bid_i` in REQID: response ID (ignored).
- `bresp_i` in 2: write response.
- `done_o` out 1: one-cycle pulse when the final burst of a packet is acknowledged.
- `error_o` out 1: sticky; set by any `bresp_i != 0`.
- `bytes_o` out 16: bytes accepted since reset, wrapping.

## Operation
- FSM states: ST_FILL, ST_ADDR, ST_DATA, ST_RESP. Reset state is ST_FILL.
- ST_FILL: `s_ready_o`=1. Each accepted byte goes into lane `k` of the packer; `k` counts 0..3.
  - On lane 3 or `s_last_i`, the word and its strobes are written to the buffer. A partial word has strobes only for the filled lanes (e.g. 2 bytes gives 4'b0011). `k` then returns to 0.
  - The burst closes when buffer count reaches `beats_to_boundary`, or on the `s_last_i` word. Then go to ST_ADDR.
  - `beats_to_boundary` = BURST_LEN − (addr[log2(BURST_LEN*4)-1:2]).
- ST_ADDR: `awvalid_o`=1 with `awlen_o`=count−1, `awaddr_o`=addr, `awid_o`=id. On `awready_i`, go to ST_DATA.
- ST_DATA: beats are read out of the buffer in order, one per `wready_i` cycle. `wlast_o` is set on beat count−1. After the last handshake, go to ST_RESP.
- ST_RESP: `bready_o`=1. On `bvalid_i`:
  - addr += 4·count, modulo 2^ADDRS.
  - id += 1, wrapping.
  - Buffer is cleared.
  - `error_o` |= (`bresp_i != 0`).
  - `done_o` pulses if the burst held the packet's last word.
  - Return to ST_FILL.
- `s_ready_o` is 0 in every state except ST_FILL. No AW/W overlap with filling.
- A packet always restarts at lane 0. The next packet begins at the next word address; there is no byte packing across packets.
- Reset mid-operation: all state is dropped at once; any outstanding AXI transaction is abandoned.
- Reset values:
  - `s_ready_o`, `awvalid_o`, `wvalid_o`, `wlast_o`, `bready_o`, `done_o`, `error_o` = 0.
  - `awaddr_o` = BASE_ADDR; `awid_o`, `awlen_o`, `wstrb_o`, `wdata_o`, `bytes_o` = 0.
  - `awburst_o` = 2'b01.

## Timing
- All outputs are registered.
- `s_ready_o` rises in the first cycle after reset deasserts.
- One byte is accepted per cycle in ST_FILL.
- `awvalid_o` is high in the cycle after the handshake of the burst-closing byte.
- `wvalid_o` is high in the cycle after the AW handshake, with back-to-back beats while `wready_i`=1.
- `bready_o` is high in the cycle after the `wlast_o` handshake.
- After the B handshake: `s_ready_o`=1 and the `done_o` pulse occur in the next cycle.
- `awvalid_o`/`wvalid_o` are held, with payload stable, until accepted.

## Structure
- Shared package holds: the state encoding, `AXI_BURST_INCR`=2'b01, the `AXI_RESP_OKAY` constant, and the `beats_to_boundary` function.
- Sub-module: `sync_fifo` (WIDTH 36 = {strb,data}, ABITS log2(BURST_LEN), OUTREG 0) serves as the burst buffer. The FSM, packer and address counter stay in this module.

## Test plan
- 64-byte packet 0x00..0x3F at BASE_ADDR 0:
  - one AW with awaddr=0, awlen=15, id=0;
  - 16 beats, first wdata=0x03020100, strobes 4'hF, wlast on beat 16;
  - `done_o` pulses once; `bytes_o`=64.
- 6-byte packet: awlen=1; beat 1 strb=4'hF; beat 2 strb=4'b0011 carrying bytes 4..5 in [15:0]; next address = 8.
- Packet starting at addr 0x38 with 40 bytes:
  - burst 1: awaddr=0x38, awlen=1 (boundary);
  - burst 2: awaddr=0x40, awlen=7;
  - `done_o` only after burst 2.
- `awready_i` held low for 10 cycles, `wready_i` toggling: payload stable, `s_ready_o`=0 throughout, no beats lost.
- `bresp_i`=2'b10 on the first burst: `error_o` sets and stays 1 through later OKAY bursts, until reset.
- Reset asserted during ST_DATA:
  - all valids drop at once; awaddr returns to BASE_ADDR;
  - the next packet starts with id=0, lane 0.

Source files
------------

// File: rtl/axis_axi_writer_pkg.sv
// Shared types and constants for the byte-stream to AXI4 write-burst engine.
package axis_axi_writer_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Beats left before the next burst-size-aligned boundary (burst_len is a power of two).
  function automatic int unsigned beats_to_boundary(input int unsigned word_index,
                                                    input int unsigned burst_len);
    return burst_len - (word_index & (burst_len - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the one-burst buffer; OUTREG=0 gives a show-ahead head word.
module sync_fifo #(
  parameter int WIDTH  = 36,
  parameter int ABITS  = 4,
  parameter int OUTREG = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [ABITS:0]   count
);

  logic [WIDTH-1:0] mem [2**ABITS];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ABITS+1)'(wr_en) - (ABITS+1)'(rd_en);
    end
  end

  if (OUTREG == 0) begin : g_show_ahead
    assign rd_data = mem[rd_ptr];
  end else begin : g_out_reg
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clock) rd_q <= mem[rd_ptr];
    assign rd_data = rd_q;
  end

endmodule

// File: rtl/axis_axi_writer.sv
// Packs a byte stream little-endian into 32-bit words and writes it out as
// boundary-safe AXI4 INCR bursts at an auto-incrementing address.
module axis_axi_writer
  import axis_axi_writer_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               ADDRS     = 27,
  parameter int               REQID     = 4,
  parameter int               BURST_LEN = 16,
  parameter logic [ADDRS-1:0] BASE_ADDR = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic               s_last_i,
  input  logic [7:0]         s_data_i,
  output logic               awvalid_o,
  input  logic               awready_i,
  output logic [ADDRS-1:0]   awaddr_o,
  output logic [REQID-1:0]   awid_o,
  output logic [7:0]         awlen_o,
  output logic [1:0]         awburst_o,
  output logic               wvalid_o,
  input  logic               wready_i,
  output logic               wlast_o,
  output logic [WIDTH/8-1:0] wstrb_o,
  output logic [WIDTH-1:0]   wdata_o,
  input  logic               bvalid_i,
  output logic               bready_o,
  input  logic [REQID-1:0]   bid_i,
  input  logic [1:0]         bresp_i,
  output logic               done_o,
  output logic               error_o,
  output logic [15:0]        bytes_o
);

  localparam int ABITS = $clog2(BURST_LEN);
  localparam int CW    = ABITS + 1;

  state_t state, state_next;

  logic [1:0]         lane;
  logic [WIDTH-1:0]   word, word_next;
  logic [3:0]         strb, strb_next;
  logic [CW-1:0]      fifo_count;
  logic [WIDTH+3:0]   fifo_rd;
  logic               fifo_rd_en;
  logic [CW-1:0]      beats;
  logic [CW-1:0]      beats_loaded;
  logic               last_burst;
  logic               s_hs, aw_hs, w_hs, b_hs;
  logic               word_done, burst_close;

  logic unused_bid;
  assign unused_bid = ^bid_i;

  assign awburst_o = AXI_BURST_INCR;

  sync_fifo #(
    .WIDTH (WIDTH + 4),
    .ABITS (ABITS),
    .OUTREG(0)
  ) u_buffer (
    .clock  (clock),
    .reset  (reset),
    .clear  (b_hs),
    .wr_en  (word_done),
    .wr_data({strb_next, word_next}),
    .rd_en  (fifo_rd_en),
    .rd_data(fifo_rd),
    .count  (fifo_count)
  );

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FILL;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next  = state;
    word_next   = word;
    strb_next   = strb;
    s_hs        = s_valid_i && s_ready_o;
    aw_hs       = awvalid_o && awready_i;
    w_hs        = wvalid_o && wready_i;
    b_hs        = bvalid_i && bready_o;
    word_next[{lane, 3'b000} +: 8] = s_data_i;
    strb_next[lane]                = 1'b1;
    word_done   = s_hs && (lane == 2'd3 || s_last_i);
    burst_close = word_done &&
                  (s_last_i || (32'(fifo_count) + 32'd1 ==
                                beats_to_boundary(32'(awaddr_o[ADDRS-1:2]), BURST_LEN)));
    fifo_rd_en  = aw_hs || (w_hs && !wlast_o);
    case (state)
      ST_FILL: if (burst_close)       state_next = ST_ADDR;
      ST_ADDR: if (aw_hs)             state_next = ST_DATA;
      ST_DATA: if (w_hs && wlast_o)   state_next = ST_RESP;
      ST_RESP: if (b_hs)              state_next = ST_FILL;
      default:                        state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_ready_o    <= 1'b0;
      awvalid_o    <= 1'b0;
      wvalid_o     <= 1'b0;
      wlast_o      <= 1'b0;
      bready_o     <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      awaddr_o     <= BASE_ADDR;
      awid_o       <= '0;
      awlen_o      <= '0;
      wstrb_o      <= '0;
      wdata_o      <= '0;
      bytes_o      <= '0;
      lane         <= '0;
      word         <= '0;
      strb         <= '0;
      beats        <= '0;
      beats_loaded <= '0;
      last_burst   <= 1'b0;
    end else begin
      s_ready_o <= (state_next == ST_FILL);
      awvalid_o <= (state_next == ST_ADDR);
      wvalid_o  <= (state_next == ST_DATA);
      bready_o  <= (state_next == ST_RESP);
      done_o    <= 1'b0;

      if (s_hs) begin
        bytes_o <= bytes_o + 16'd1;
        if (word_done) begin
          lane <= '0;
          word <= '0;
          strb <= '0;
        end else begin
          lane <= lane + 2'd1;
          word <= word_next;
          strb <= strb_next;
        end
      end

      if (burst_close) begin
        awlen_o    <= 8'(fifo_count);
        beats      <= fifo_count + CW'(1);
        last_burst <= s_last_i;
      end

      // The buffer head is copied into the W output register as each beat is presented.
      if (aw_hs) begin
        {wstrb_o, wdata_o} <= fifo_rd;
        beats_loaded       <= CW'(1);
        wlast_o            <= (beats == CW'(1));
      end else if (w_hs && !wlast_o) begin
        {wstrb_o, wdata_o} <= fifo_rd;
        beats_loaded       <= beats_loaded + CW'(1);
        wlast_o            <= (beats_loaded + CW'(1) == beats);
      end else if (w_hs) begin
        wlast_o <= 1'b0;
      end

      if (b_hs) begin
        awaddr_o <= awaddr_o + (ADDRS'(beats) << 2);
        awid_o   <= awid_o + REQID'(1);
        error_o  <= error_o | (bresp_i != AXI_RESP_OKAY);
        done_o   <= last_burst;
      end
    end
  end

endmodule
